// File: rtl/instr_loader_pkg.sv
// Shared constants, opcode values and loader FSM encoding for the
// serial instruction loader.
package instr_loader_pkg;

    localparam int WORD_W = 10;
    localparam int CNT_W  = 3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DOT = 2'b10;
    localparam logic [1:0] OP_MAC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LAST  = 2'd2,
        ST_HOLD  = 2'd3
    } ld_state_e;

    // HOLD means the last bit is pending and there is nowhere to put the word.
    function automatic ld_state_e state_of(input logic [3:0] cnt, input logic full);
        ld_state_e st;
        case (cnt)
            4'd0:    st = ST_IDLE;
            4'd9:    st = full ? ST_HOLD : ST_LAST;
            default: st = ST_SHIFT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small instruction word FIFO; head word is read straight from storage so it
// is visible the cycle after a push into an empty FIFO.
module instr_fifo #(
    parameter int DEPTH  = 2,
    parameter int WORD_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic [2:0]        count
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [2:0]        count_r;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= 3'd0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= 3'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (push && !pop) begin
                count_r <= count_r + 3'd1;
            end else if (pop && !push) begin
                count_r <= count_r - 3'd1;
            end
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/instr_loader.sv
// Serial-to-parallel instruction loader: assembles 10-bit words MSB first and
// queues them for the ALU stage, splitting the head into ain/bin/func.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [3:0] ain,
    output logic [3:0] bin,
    output logic [1:0] func,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] word_count
);

    logic [3:0]        bit_cnt_r;
    logic [WORD_W-1:0] asm_r;
    logic [7:0]        word_count_r;
    ld_state_e         state_r;
    ld_state_e         state_s;
    logic [3:0]        cnt_next_s;
    logic [2:0]        fill_next_s;
    logic [2:0]        fifo_count_s;
    logic [WORD_W-1:0] head_s;
    logic [WORD_W-1:0] push_word_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              out_valid_s;

    assign out_valid_s = (fifo_count_s != 3'd0);
    assign bit_ready   = (state_r != ST_HOLD);
    assign accept_s    = bit_valid && bit_ready && !flush;
    assign push_s      = accept_s && (bit_cnt_r == 4'd9);
    assign pop_s       = out_valid_s && out_ready && !flush;
    assign push_word_s = {asm_r[WORD_W-2:0], bit_in};

    instr_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push_s),
        .push_data (push_word_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_count_s)
    );

    // Next bit count, next occupancy and the FSM state they imply.
    always_comb begin
        cnt_next_s  = bit_cnt_r;
        fill_next_s = fifo_count_s;
        if (flush) begin
            cnt_next_s  = 4'd0;
            fill_next_s = 3'd0;
        end else begin
            if (accept_s) begin
                cnt_next_s = (bit_cnt_r == 4'd9) ? 4'd0 : (bit_cnt_r + 4'd1);
            end else begin
                cnt_next_s = bit_cnt_r;
            end
            fill_next_s = fifo_count_s + {2'b00, push_s} - {2'b00, pop_s};
        end
        state_s = state_of(cnt_next_s, fill_next_s >= 3'(DEPTH));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Bit counter, assembly shifter and pop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r    <= 4'd0;
            asm_r        <= '0;
            word_count_r <= 8'd0;
        end else begin
            bit_cnt_r <= cnt_next_s;
            if (flush) begin
                asm_r <= '0;
            end else if (accept_s) begin
                asm_r <= push_word_s;
            end
            if (pop_s) begin
                word_count_r <= word_count_r + 8'd1;
            end
        end
    end

    // Head word fields are forced to zero whenever nothing is queued.
    always_comb begin
        if (out_valid_s) begin
            ain  = head_s[9:6];
            bin  = head_s[5:2];
            func = head_s[1:0];
        end else begin
            ain  = 4'd0;
            bin  = 4'd0;
            func = 2'd0;
        end
    end

    assign out_valid  = out_valid_s;
    assign word_count = word_count_r;

endmodule
